// File: rtl/gmii_mii_adapter.sv
// GMII/MII adapter between MAC and PHY: byte pass-through in GMII mode, nibble
// serialise/assemble in MII mode, PIPE_STAGES output pipeline, saturating RX error counter.
//
// TX FSM (MII mode only, advances on mii_ce)
// state   | meaning
// TX_IDLE | no frame; an accepted byte emits its low nibble
// TX_LOW  | low nibble on the wire; next strobe emits the high nibble
// TX_HIGH | high nibble on the wire; accept another byte or end the frame

module gmii_mii_adapter #(
  parameter int PIPE_STAGES = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock_125MHz,
  input  logic                 reset,
  input  logic                 speed_mii,
  input  logic                 mii_ce,
  input  logic                 stat_clear,
  input  logic [7:0]           mac_txd,
  input  logic                 mac_tx_en,
  input  logic                 mac_tx_er,
  output logic                 mac_tx_ready,
  output logic [7:0]           phy_txd,
  output logic                 phy_tx_en,
  output logic                 phy_tx_er,
  input  logic [7:0]           phy_rxd,
  input  logic                 phy_rx_dv,
  input  logic                 phy_rx_er,
  input  logic                 phy_col,
  input  logic                 phy_crs,
  output logic [7:0]           mac_rxd,
  output logic                 mac_rx_valid,
  output logic                 mac_rx_dv,
  output logic                 mac_rx_er,
  output logic                 mac_col,
  output logic                 mac_crs,
  output logic [CNT_WIDTH-1:0] rx_err_count
);

  localparam int PW = 23;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOW  = 2'd1,
    TX_HIGH = 2'd2
  } tx_state_t;

  tx_state_t            tx_state_q, tx_state_d;
  logic                 alive_q, alive_d;
  logic                 mode_q, mode_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 tx_er_q, tx_er_d;
  logic [9:0]           tx_drv_q, tx_drv_d;
  logic                 nib_valid_q, nib_valid_d;
  logic [3:0]           nib_q, nib_d;
  logic                 sticky_q, sticky_d;
  logic                 rx_frame_q, rx_frame_d;
  logic                 frame_err_q, frame_err_d;
  logic [7:0]           rx_byte_q, rx_byte_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]        pipe_q [PIPE_STAGES];
  logic [PW-1:0]        pipe_d [PIPE_STAGES];

  logic       tx_ready, tx_accept, samp;
  logic       rx_valid_now, rx_er_now, rx_dv_now, err_inc;
  logic [9:0] tx_path;
  logic [7:0] rxd_path;
  logic       valid_path, dv_path, er_path;

  always_comb begin
    alive_d      = 1'b1;
    mode_d       = mode_q;
    tx_state_d   = tx_state_q;
    tx_byte_d    = tx_byte_q;
    tx_er_d      = tx_er_q;
    tx_drv_d     = tx_drv_q;
    nib_valid_d  = nib_valid_q;
    nib_d        = nib_q;
    sticky_d     = sticky_q;
    rx_frame_d   = rx_frame_q;
    frame_err_d  = frame_err_q;
    rx_byte_d    = rx_byte_q;
    cnt_d        = cnt_q;
    rx_valid_now = 1'b0;
    rx_er_now    = 1'b0;
    rx_dv_now    = rx_frame_q;
    err_inc      = 1'b0;

    tx_ready  = alive_q & (mode_q ? (mii_ce & ((tx_state_q == TX_IDLE) ||
                                                (tx_state_q == TX_HIGH))) : 1'b1);
    tx_accept = mode_q & tx_ready & mac_tx_en;

    if (mode_q && mii_ce) begin
      case (tx_state_q)
        TX_IDLE, TX_HIGH: begin
          if (tx_accept) begin
            tx_byte_d  = mac_txd;
            tx_er_d    = mac_tx_er;
            tx_drv_d   = {1'b1, mac_tx_er, 4'h0, mac_txd[3:0]};
            tx_state_d = TX_LOW;
          end else begin
            tx_drv_d   = '0;
            tx_state_d = TX_IDLE;
          end
        end
        TX_LOW: begin
          tx_drv_d   = {1'b1, tx_er_q, 4'h0, tx_byte_q[7:4]};
          tx_state_d = TX_HIGH;
        end
        default: begin
          tx_drv_d   = '0;
          tx_state_d = TX_IDLE;
        end
      endcase
    end

    // Switch modes only between frames so a byte is never split across modes
    if ((tx_state_q == TX_IDLE) && !tx_accept && !phy_rx_dv && !nib_valid_q)
      mode_d = speed_mii;

    samp = mode_q ? mii_ce : 1'b1;
    if (samp) begin
      rx_frame_d = phy_rx_dv;
      rx_dv_now  = phy_rx_dv;
      if (phy_rx_dv) begin
        frame_err_d = frame_err_q | phy_rx_er;
        if (mode_q) begin
          if (!nib_valid_q) begin
            nib_d       = phy_rxd[3:0];
            nib_valid_d = 1'b1;
            sticky_d    = phy_rx_er;
          end else begin
            rx_byte_d    = {phy_rxd[3:0], nib_q};
            rx_valid_now = 1'b1;
            rx_er_now    = sticky_q | phy_rx_er;
            nib_valid_d  = 1'b0;
            sticky_d     = 1'b0;
          end
        end
      end else begin
        if (nib_valid_q) begin
          rx_er_now   = 1'b1;
          nib_valid_d = 1'b0;
          sticky_d    = 1'b0;
        end
        if (rx_frame_q)
          err_inc = frame_err_q | nib_valid_q;
        frame_err_d = 1'b0;
      end
    end

    if (stat_clear)
      cnt_d = '0;
    else if (err_inc && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_d = cnt_q + CNT_WIDTH'(1);

    tx_path    = mode_q ? tx_drv_d     : {mac_tx_en, mac_tx_er, mac_txd};
    rxd_path   = mode_q ? rx_byte_d    : phy_rxd;
    valid_path = mode_q ? rx_valid_now : phy_rx_dv;
    dv_path    = mode_q ? rx_dv_now    : phy_rx_dv;
    er_path    = mode_q ? rx_er_now    : phy_rx_er;

    pipe_d[0] = {tx_path, rxd_path, valid_path, dv_path, er_path, phy_col, phy_crs};
    for (int i = 1; i < PIPE_STAGES; i++)
      pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clock_125MHz or negedge reset) begin
    if (!reset) begin
      tx_state_q  <= TX_IDLE;
      alive_q     <= 1'b0;
      mode_q      <= 1'b0;
      tx_byte_q   <= '0;
      tx_er_q     <= 1'b0;
      tx_drv_q    <= '0;
      nib_valid_q <= 1'b0;
      nib_q       <= '0;
      sticky_q    <= 1'b0;
      rx_frame_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_byte_q   <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < PIPE_STAGES; i++)
        pipe_q[i] <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      alive_q     <= alive_d;
      mode_q      <= mode_d;
      tx_byte_q   <= tx_byte_d;
      tx_er_q     <= tx_er_d;
      tx_drv_q    <= tx_drv_d;
      nib_valid_q <= nib_valid_d;
      nib_q       <= nib_d;
      sticky_q    <= sticky_d;
      rx_frame_q  <= rx_frame_d;
      frame_err_q <= frame_err_d;
      rx_byte_q   <= rx_byte_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < PIPE_STAGES; i++)
        pipe_q[i] <= pipe_d[i];
    end
  end

  assign mac_tx_ready = tx_ready;
  assign rx_err_count = cnt_q;
  assign {phy_tx_en, phy_tx_er, phy_txd, mac_rxd, mac_rx_valid, mac_rx_dv,
          mac_rx_er, mac_col, mac_crs} = pipe_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_gmii_mii_adapter.sv
// Self-checking bench for gmii_mii_adapter: randomized frames checked against a
// frame/nibble-level reference model with a PIPE_STAGES output delay.

module tb_gmii_mii_adapter;

  localparam int P    = 2;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock_125MHz = 1'b0;
  logic          reset;
  logic          speed_mii, mii_ce, stat_clear;
  logic [7:0]    mac_txd;
  logic          mac_tx_en, mac_tx_er, mac_tx_ready;
  logic [7:0]    phy_txd;
  logic          phy_tx_en, phy_tx_er;
  logic [7:0]    phy_rxd;
  logic          phy_rx_dv, phy_rx_er, phy_col, phy_crs;
  logic [7:0]    mac_rxd;
  logic          mac_rx_valid, mac_rx_dv, mac_rx_er, mac_col, mac_crs;
  logic [CW-1:0] rx_err_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  gmii_mii_adapter #(.PIPE_STAGES(P), .CNT_WIDTH(CW)) dut (
    .clock_125MHz(clock_125MHz), .reset(reset), .speed_mii(speed_mii),
    .mii_ce(mii_ce), .stat_clear(stat_clear),
    .mac_txd(mac_txd), .mac_tx_en(mac_tx_en), .mac_tx_er(mac_tx_er),
    .mac_tx_ready(mac_tx_ready),
    .phy_txd(phy_txd), .phy_tx_en(phy_tx_en), .phy_tx_er(phy_tx_er),
    .phy_rxd(phy_rxd), .phy_rx_dv(phy_rx_dv), .phy_rx_er(phy_rx_er),
    .phy_col(phy_col), .phy_crs(phy_crs),
    .mac_rxd(mac_rxd), .mac_rx_valid(mac_rx_valid), .mac_rx_dv(mac_rx_dv),
    .mac_rx_er(mac_rx_er), .mac_col(mac_col), .mac_crs(mac_crs),
    .rx_err_count(rx_err_count)
  );

  always #4 clock_125MHz = ~clock_125MHz;

  task automatic tick();
    @(posedge clock_125MHz);
    #1;
  endtask

  task automatic drive_idle();
    mii_ce = 0; stat_clear = 0;
    mac_txd = 0; mac_tx_en = 0; mac_tx_er = 0;
    phy_rxd = 0; phy_rx_dv = 0; phy_rx_er = 0; phy_col = 0; phy_crs = 0;
  endtask

  task automatic set_mode(input logic m);
    speed_mii = m;
    drive_idle();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 0; speed_mii = 0;
    drive_idle();
    mac_tx_en = 1; mac_txd = 8'hFF; phy_rx_dv = 1; phy_col = 1; phy_crs = 1;
    repeat (3) tick();
    n_checks++;
    if ({phy_tx_en, phy_tx_er, phy_txd, mac_rxd, mac_rx_valid, mac_rx_dv, mac_rx_er,
         mac_col, mac_crs, mac_tx_ready} !== 23'd0)
      $display("FAIL reset_outputs: got tx=%b/%b/%h rx=%h/%b/%b/%b col=%b crs=%b rdy=%b, expected all 0",
               phy_tx_en, phy_tx_er, phy_txd, mac_rxd, mac_rx_valid, mac_rx_dv, mac_rx_er,
               mac_col, mac_crs, mac_tx_ready);
    else n_pass++;
    n_checks++;
    if (rx_err_count !== '0) $display("FAIL reset_count: got %0d expected 0", rx_err_count);
    else n_pass++;
    drive_idle();
    reset = 1;
    repeat (3) tick();
    n_checks++;
    if (mac_tx_ready !== 1'b1) $display("FAIL reset_ready_gmii: got %b expected 1", mac_tx_ready);
    else n_pass++;
    exp_cnt = 0;
  endtask

  task automatic test_gmii();
    logic [9:0]  th[$];
    logic [12:0] rh[$];
    logic [9:0]  te;
    logic [12:0] re;
    bit in_frame = 0, ferr = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i >= P) begin
        te = th[i-P]; re = rh[i-P];
        n_checks++;
        if ({phy_tx_en, phy_tx_er, phy_txd} !== te)
          $display("FAIL gmii_tx cycle %0d: got %b expected %b", i, {phy_tx_en, phy_tx_er, phy_txd}, te);
        else n_pass++;
        n_checks++;
        if ({mac_rxd, mac_rx_valid, mac_rx_dv, mac_rx_er, mac_col, mac_crs} !== re)
          $display("FAIL gmii_rx cycle %0d: got %b expected %b", i,
                   {mac_rxd, mac_rx_valid, mac_rx_dv, mac_rx_er, mac_col, mac_crs}, re);
        else n_pass++;
        n_checks++;
        if (mac_tx_ready !== 1'b1) $display("FAIL gmii_ready cycle %0d: got %b expected 1", i, mac_tx_ready);
        else n_pass++;
      end
      speed_mii = 0;
      mii_ce    = 1'($urandom);
      mac_tx_en = (i < 64);
      mac_txd   = 8'($urandom);
      mac_tx_er = (i < 64) && ($urandom_range(0, 15) == 0);
      phy_rx_dv = (i < 90) && ($urandom_range(0, 3) != 0);
      phy_rx_er = ($urandom_range(0, 7) == 0);
      phy_rxd   = 8'($urandom);
      phy_col   = 1'($urandom);
      phy_crs   = 1'($urandom);
      th.push_back({mac_tx_en, mac_tx_er, mac_txd});
      rh.push_back({phy_rxd, phy_rx_dv, phy_rx_dv, phy_rx_er, phy_col, phy_crs});
      if (phy_rx_dv) begin
        ferr = ferr | phy_rx_er;
        in_frame = 1;
      end else if (in_frame) begin
        if (ferr && exp_cnt < CMAX) exp_cnt++;
        in_frame = 0; ferr = 0;
      end
    end
    tick();
    n_checks++;
    if (rx_err_count !== CW'(exp_cnt))
      $display("FAIL gmii_err_count: got %0d expected %0d", rx_err_count, exp_cnt);
    else n_pass++;
    drive_idle();
  endtask

  task automatic test_mii_tx(input int nbytes, input bit directed, input bit toggle);
    logic [7:0] bytes[$];
    logic       ers[$];
    logic [9:0] th[$];
    logic [9:0] cur, te;
    logic [7:0] cb;
    int k, b, nstrobe, total;
    if (directed) begin
      bytes = '{8'h55, 8'hD5, 8'hA3};
      ers   = '{1'b0, 1'b0, 1'b0};
    end else begin
      for (int j = 0; j < nbytes; j++) begin
        bytes.push_back(8'($urandom));
        ers.push_back($urandom_range(0, 3) == 0);
      end
    end
    nstrobe = 2 * nbytes + 1;
    total   = nstrobe * 5 + P + 3;
    cur = '0; k = 0;
    for (int i = 0; i < total; i++) begin
      tick();
      if (i >= P) begin
        te = th[i-P];
        n_checks++;
        if ({phy_tx_en, phy_tx_er, phy_txd} !== te)
          $display("FAIL mii_tx_out cycle %0d: got %b expected %b", i, {phy_tx_en, phy_tx_er, phy_txd}, te);
        else n_pass++;
      end
      if ((i % 5 == 0) && (k < nstrobe)) begin
        mii_ce = 1;
        b = k / 2;
        if (k % 2 == 0) begin
          if (b < nbytes) begin
            cb = bytes[b];
            mac_tx_en = 1; mac_txd = cb; mac_tx_er = ers[b];
            cur = {1'b1, ers[b], 4'h0, cb[3:0]};
          end else begin
            mac_tx_en = 0; mac_txd = 0; mac_tx_er = 0;
            cur = '0;
          end
        end else begin
          cb  = bytes[b];
          cur = {1'b1, ers[b], 4'h0, cb[7:4]};
        end
        if (toggle && k == 1) speed_mii = 0;
        #1;
        n_checks++;
        if (mac_tx_ready !== (k % 2 == 0))
          $display("FAIL mii_tx_ready strobe %0d: got %b expected %b", k, mac_tx_ready, (k % 2 == 0));
        else n_pass++;
        k++;
      end else begin
        mii_ce = 0;
        if (k < nstrobe) begin
          #1;
          n_checks++;
          if (mac_tx_ready !== 1'b0)
            $display("FAIL mii_tx_ready_gap cycle %0d: got %b expected 0", i, mac_tx_ready);
          else n_pass++;
        end
      end
      th.push_back(cur);
    end
    if (toggle) begin
      th.delete();
      for (int i = 0; i < 12; i++) begin
        tick();
        if (i >= P) begin
          te = th[i-P];
          n_checks++;
          if ({phy_tx_en, phy_tx_er, phy_txd} !== te)
            $display("FAIL mode_switch_gmii_tx cycle %0d: got %b expected %b", i,
                     {phy_tx_en, phy_tx_er, phy_txd}, te);
          else n_pass++;
          n_checks++;
          if (mac_tx_ready !== 1'b1)
            $display("FAIL mode_switch_ready cycle %0d: got %b expected 1", i, mac_tx_ready);
          else n_pass++;
        end
        mac_tx_en = 1'($urandom); mac_tx_er = 1'($urandom); mac_txd = 8'($urandom);
        th.push_back({mac_tx_en, mac_tx_er, mac_txd});
      end
    end
    drive_idle();
  endtask

  task automatic test_mii_rx(input int nnib, input bit directed);
    logic [3:0]  nibs[$];
    logic        ers[$];
    logic [12:0] rh[$];
    logic [12:0] re;
    logic [7:0]  rxd_e;
    logic        valid, er, dv_state, ferr;
    int k, nstrobe, total;
    if (directed) begin
      stat_clear = 1;
      tick();
      stat_clear = 0;
      exp_cnt = 0;
      nibs = '{4'h5, 4'h5, 4'h5, 4'hD, 4'h3, 4'hA};
      ers  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    end else begin
      for (int j = 0; j < nnib; j++) begin
        nibs.push_back(4'($urandom));
        ers.push_back($urandom_range(0, 7) == 0);
      end
    end
    ferr = (nnib % 2 == 1);
    for (int j = 0; j < nnib; j++) ferr = ferr | ers[j];
    nstrobe = nnib + 1;
    total   = nstrobe * 5 + P + 3;
    k = 0; dv_state = 0;
    for (int i = 0; i < total; i++) begin
      tick();
      if (i >= P) begin
        re = rh[i-P];
        n_checks++;
        if ({mac_rx_valid, mac_rx_dv, mac_rx_er, mac_col, mac_crs} !== re[4:0])
          $display("FAIL mii_rx_ctrl cycle %0d: got %b expected %b", i,
                   {mac_rx_valid, mac_rx_dv, mac_rx_er, mac_col, mac_crs}, re[4:0]);
        else n_pass++;
        if (re[4]) begin
          n_checks++;
          if (mac_rxd !== re[12:5])
            $display("FAIL mii_rx_byte cycle %0d: got %h expected %h", i, mac_rxd, re[12:5]);
          else n_pass++;
        end
      end
      phy_col = 1'($urandom);
      phy_crs = 1'($urandom);
      valid = 0; er = 0; rxd_e = '0;
      if ((i % 5 == 0) && (k < nstrobe)) begin
        mii_ce = 1;
        if (k < nnib) begin
          phy_rx_dv = 1;
          phy_rxd   = {4'($urandom), nibs[k]};
          phy_rx_er = ers[k];
          dv_state  = 1;
          if (k % 2 == 1) begin
            valid = 1;
            rxd_e = {nibs[k], nibs[k-1]};
            er    = ers[k] | ers[k-1];
          end
        end else begin
          phy_rx_dv = 0;
          phy_rxd   = 8'($urandom);
          phy_rx_er = 0;
          dv_state  = 0;
          er        = (nnib % 2 == 1);
        end
        k++;
      end else begin
        mii_ce    = 0;
        phy_rxd   = 8'($urandom);
        phy_rx_er = 1'($urandom);
      end
      rh.push_back({rxd_e, valid, dv_state, er, phy_col, phy_crs});
    end
    if (ferr && exp_cnt < CMAX) exp_cnt++;
    n_checks++;
    if (rx_err_count !== CW'(exp_cnt))
      $display("FAIL mii_rx_err_count nnib=%0d: got %0d expected %0d", nnib, rx_err_count, exp_cnt);
    else n_pass++;
    drive_idle();
  endtask

  task automatic test_counter();
    drive_idle();
    for (int f = 0; f < CMAX + 5; f++) begin
      phy_rx_dv = 1; phy_rx_er = 1;
      tick();
      phy_rx_dv = 0; phy_rx_er = 0;
      tick();
      if (exp_cnt < CMAX) exp_cnt++;
    end
    tick();
    n_checks++;
    if (rx_err_count !== CW'(exp_cnt))
      $display("FAIL count_saturate: got %0d expected %0d", rx_err_count, exp_cnt);
    else n_pass++;
    phy_rx_dv = 1; phy_rx_er = 1;
    tick();
    phy_rx_dv = 0; phy_rx_er = 0; stat_clear = 1;
    tick();
    stat_clear = 0; exp_cnt = 0;
    tick();
    n_checks++;
    if (rx_err_count !== CW'(exp_cnt))
      $display("FAIL count_clear_priority: got %0d expected %0d", rx_err_count, exp_cnt);
    else n_pass++;
    phy_rx_dv = 1;
    repeat (3) tick();
    phy_rx_dv = 0;
    repeat (2) tick();
    n_checks++;
    if (rx_err_count !== CW'(exp_cnt))
      $display("FAIL count_clean_frame: got %0d expected %0d", rx_err_count, exp_cnt);
    else n_pass++;
    phy_rx_dv = 1;
    tick();
    phy_rx_er = 1;
    tick();
    phy_rx_er = 0;
    tick();
    phy_rx_dv = 0;
    repeat (2) tick();
    exp_cnt = 1;
    n_checks++;
    if (rx_err_count !== CW'(exp_cnt))
      $display("FAIL count_one_per_frame: got %0d expected %0d", rx_err_count, exp_cnt);
    else n_pass++;
    drive_idle();
  endtask

  task automatic test_reset_midframe();
    set_mode(1);
    for (int i = 0; i < 12; i++) begin
      tick();
      mii_ce    = (i % 5 == 0);
      mac_tx_en = 1; mac_txd = 8'hA5; mac_tx_er = 0;
      phy_rx_dv = 1; phy_rxd = 8'h07; phy_rx_er = 1;
    end
    tick();
    #1;
    reset = 0;
    #1;
    n_checks++;
    if ({phy_tx_en, phy_tx_er, phy_txd, mac_rxd, mac_rx_valid, mac_rx_dv, mac_rx_er,
         mac_col, mac_crs, mac_tx_ready} !== 23'd0)
      $display("FAIL midframe_reset_outputs: got tx_en=%b txd=%h rx_dv=%b rxd=%h rdy=%b, expected all 0",
               phy_tx_en, phy_txd, mac_rx_dv, mac_rxd, mac_tx_ready);
    else n_pass++;
    exp_cnt = 0;
    n_checks++;
    if (rx_err_count !== CW'(exp_cnt))
      $display("FAIL midframe_reset_count: got %0d expected 0", rx_err_count);
    else n_pass++;
    speed_mii = 0;
    drive_idle();
    #2;
    reset = 1;
    repeat (3) tick();
    n_checks++;
    if ({phy_tx_en, mac_rx_dv, mac_rx_valid, mac_tx_ready} !== 4'b0001)
      $display("FAIL post_reset_state: got tx_en=%b rx_dv=%b rx_valid=%b ready=%b expected 0/0/0/1",
               phy_tx_en, mac_rx_dv, mac_rx_valid, mac_tx_ready);
    else n_pass++;
    set_mode(1);
    test_mii_tx(2, 0, 0);
  endtask

  initial begin
    reset = 0;
    speed_mii = 0;
    drive_idle();
    test_reset();
    test_gmii();
    set_mode(1);
    test_mii_tx(3, 1, 0);
    test_mii_tx(5, 0, 0);
    test_mii_rx(6, 1);
    test_mii_rx(8, 0);
    test_mii_rx(5, 0);
    test_mii_rx(7, 0);
    test_mii_tx(3, 0, 1);
    test_counter();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
